// File: rtl/lsm_step_sequencer.sv
// Backward-induction controller for the Longstaff-Schwartz regression stage: streams each
// exercise step's paths into the accumulator and writes the returned betas to the coefficient store.
module lsm_step_sequencer #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned N_PATHS = 10,
   parameter int unsigned N_STEPS = 8,
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned TIMEOUT = 1024,
   localparam int unsigned STEP_W = $clog2(N_STEPS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              err_timeout,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic [WIDTH-1:0]  mem_rd_x,
   input  logic [WIDTH-1:0]  mem_rd_y,
   output logic              acc_valid,
   input  logic              acc_ready,
   output logic [WIDTH-1:0]  acc_x,
   output logic [WIDTH-1:0]  acc_y,
   input  logic              acc_beta_valid,
   output logic              acc_beta_ready,
   input  logic [WIDTH-1:0]  acc_beta [0:2],
   output logic              coef_we,
   output logic [STEP_W-1:0] coef_step,
   output logic [WIDTH-1:0]  coef_beta [0:2]
);

   localparam int unsigned PATH_W    = (N_PATHS > 1) ? $clog2(N_PATHS) : 1;
   localparam int unsigned ADDR_NEED = (N_STEPS * N_PATHS > 1) ? $clog2(N_STEPS * N_PATHS) : 1;
   localparam int unsigned TMO_W     = $clog2(TIMEOUT + 1);

   if (ADDR_NEED > ADDR_W) begin : g_addr_w_chk
      $error("ADDR_W is too narrow for N_STEPS*N_PATHS-1");
   end
   if (N_STEPS < 2) begin : g_steps_chk
      $error("N_STEPS must be at least 2");
   end

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_LATCH, S_SEND, S_COLLECT, S_WRITE, S_DONE
   } state_e;

   state_e              state_q, state_d;
   logic [STEP_W-1:0]   step_q, step_d;
   logic [PATH_W-1:0]   path_q, path_d;
   logic [TMO_W-1:0]    tmo_q, tmo_d;
   logic                err_timeout_q, err_timeout_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                mem_rd_en_q, mem_rd_en_d;
   logic [ADDR_W-1:0]   mem_rd_addr_q, mem_rd_addr_d;
   logic                acc_valid_q, acc_valid_d;
   logic [WIDTH-1:0]    acc_x_q, acc_x_d;
   logic [WIDTH-1:0]    acc_y_q, acc_y_d;
   logic                acc_beta_ready_q, acc_beta_ready_d;
   logic                coef_we_q, coef_we_d;
   logic [STEP_W-1:0]   coef_step_q, coef_step_d;
   logic [WIDTH-1:0]    coef_beta_q [0:2];
   logic [WIDTH-1:0]    coef_beta_d [0:2];

   // State and counter registers plus all registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q          <= S_IDLE;
         step_q           <= '0;
         path_q           <= '0;
         tmo_q            <= '0;
         err_timeout_q    <= 1'b0;
         busy_q           <= 1'b0;
         done_q           <= 1'b0;
         mem_rd_en_q      <= 1'b0;
         mem_rd_addr_q    <= '0;
         acc_valid_q      <= 1'b0;
         acc_x_q          <= '0;
         acc_y_q          <= '0;
         acc_beta_ready_q <= 1'b0;
         coef_we_q        <= 1'b0;
         coef_step_q      <= '0;
         for (int i = 0; i < 3; i++) coef_beta_q[i] <= '0;
      end else begin
         state_q          <= state_d;
         step_q           <= step_d;
         path_q           <= path_d;
         tmo_q            <= tmo_d;
         err_timeout_q    <= err_timeout_d;
         busy_q           <= busy_d;
         done_q           <= done_d;
         mem_rd_en_q      <= mem_rd_en_d;
         mem_rd_addr_q    <= mem_rd_addr_d;
         acc_valid_q      <= acc_valid_d;
         acc_x_q          <= acc_x_d;
         acc_y_q          <= acc_y_d;
         acc_beta_ready_q <= acc_beta_ready_d;
         coef_we_q        <= coef_we_d;
         coef_step_q      <= coef_step_d;
         for (int i = 0; i < 3; i++) coef_beta_q[i] <= coef_beta_d[i];
      end
   end

   // Next state and step/path/timeout bookkeeping; abort overrides everything.
   always_comb begin
      state_d       = state_q;
      step_d        = step_q;
      path_d        = path_q;
      tmo_d         = tmo_q;
      err_timeout_d = err_timeout_q;
      if (abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_d       = S_FETCH;
                  step_d        = STEP_W'(N_STEPS - 1);
                  path_d        = '0;
                  err_timeout_d = 1'b0;
               end
            end
            S_FETCH: state_d = S_LATCH;
            S_LATCH: state_d = S_SEND;
            S_SEND: begin
               if (acc_valid_q && acc_ready) begin
                  if (path_q == PATH_W'(N_PATHS - 1)) begin
                     path_d  = '0;
                     tmo_d   = '0;
                     state_d = S_COLLECT;
                  end else begin
                     path_d  = path_q + PATH_W'(1);
                     state_d = S_FETCH;
                  end
               end
            end
            S_COLLECT: begin
               if (acc_beta_ready_q && acc_beta_valid) begin
                  state_d = S_WRITE;
               end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                  err_timeout_d = 1'b1;
                  state_d       = S_IDLE;
               end else begin
                  tmo_d = tmo_q + TMO_W'(1);
               end
            end
            S_WRITE: begin
               if (step_q == STEP_W'(1)) begin
                  state_d = S_DONE;
               end else begin
                  step_d  = step_q - STEP_W'(1);
                  state_d = S_FETCH;
               end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Outputs are decoded from the next state so each one is a flop aligned with its state.
   always_comb begin
      busy_d           = (state_d != S_IDLE);
      done_d           = (state_d == S_DONE);
      mem_rd_en_d      = (state_d == S_FETCH);
      acc_valid_d      = (state_d == S_SEND);
      acc_beta_ready_d = (state_d == S_COLLECT);
      coef_we_d        = (state_d == S_WRITE);
      mem_rd_addr_d    = '0;
      coef_step_d      = '0;
      acc_x_d          = acc_x_q;
      acc_y_d          = acc_y_q;
      for (int i = 0; i < 3; i++) coef_beta_d[i] = coef_beta_q[i];
      if (mem_rd_en_d) begin
         mem_rd_addr_d = ADDR_W'(step_d) * ADDR_W'(N_PATHS) + ADDR_W'(path_d);
      end
      if (coef_we_d) begin
         coef_step_d = step_d;
      end
      // acc_x/acc_y double as the hold registers for the sample in flight.
      if (state_q == S_LATCH) begin
         acc_x_d = mem_rd_x;
         acc_y_d = mem_rd_y;
      end
      if (state_q == S_COLLECT && state_d == S_WRITE) begin
         for (int i = 0; i < 3; i++) coef_beta_d[i] = acc_beta[i];
      end
   end

   assign busy           = busy_q;
   assign done           = done_q;
   assign err_timeout    = err_timeout_q;
   assign mem_rd_en      = mem_rd_en_q;
   assign mem_rd_addr    = mem_rd_addr_q;
   assign acc_valid      = acc_valid_q;
   assign acc_x          = acc_x_q;
   assign acc_y          = acc_y_q;
   assign acc_beta_ready = acc_beta_ready_q;
   assign coef_we        = coef_we_q;
   assign coef_step      = coef_step_q;
   assign coef_beta      = coef_beta_q;

endmodule

// File: tb/tb_lsm_step_sequencer.sv
// Directed bench for lsm_step_sequencer with a path-memory model and an accumulator stub
// that sums the received samples and returns them as beta a fixed latency later.
module tb_lsm_step_sequencer;

   localparam int N_PATHS  = 10;
   localparam int N_STEPS  = 4;
   localparam int WIDTH    = 32;
   localparam int ADDR_W   = 16;
   localparam int TIMEOUT  = 16;
   localparam int STEP_W   = $clog2(N_STEPS);
   localparam int BETA_LAT = 4;
   localparam int NOM_CYC  = 111;

   logic              clk = 1'b0;
   logic              rst_n, start, abort;
   logic              busy, done, err_timeout, mem_rd_en;
   logic [ADDR_W-1:0] mem_rd_addr;
   logic [WIDTH-1:0]  mem_rd_x, mem_rd_y;
   logic              acc_valid, acc_ready;
   logic [WIDTH-1:0]  acc_x, acc_y;
   logic              acc_beta_valid, acc_beta_ready;
   logic [WIDTH-1:0]  acc_beta [0:2];
   logic              coef_we;
   logic [STEP_W-1:0] coef_step;
   logic [WIDTH-1:0]  coef_beta [0:2];

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   lsm_step_sequencer #(
      .WIDTH(WIDTH), .N_PATHS(N_PATHS), .N_STEPS(N_STEPS), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .busy(busy), .done(done), .err_timeout(err_timeout),
      .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_x(mem_rd_x), .mem_rd_y(mem_rd_y),
      .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_x(acc_x), .acc_y(acc_y),
      .acc_beta_valid(acc_beta_valid), .acc_beta_ready(acc_beta_ready), .acc_beta(acc_beta),
      .coef_we(coef_we), .coef_step(coef_step), .coef_beta(coef_beta)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [WIDTH-1:0] mx(input int a);
      return 32'h1000_0000 + 32'(a) * 32'd7;
   endfunction
   function automatic logic [WIDTH-1:0] my(input int a);
      return 32'h2000_0000 - 32'(a) * 32'd3;
   endfunction
   function automatic int exp_addr(input int i);
      return (N_STEPS - 1 - i / N_PATHS) * N_PATHS + i % N_PATHS;
   endfunction
   function automatic logic [WIDTH-1:0] exp_sx(input int s);
      logic [WIDTH-1:0] a = '0;
      for (int p = 0; p < N_PATHS; p++) a += mx(s * N_PATHS + p);
      return a;
   endfunction
   function automatic logic [WIDTH-1:0] exp_sy(input int s);
      logic [WIDTH-1:0] a = '0;
      for (int p = 0; p < N_PATHS; p++) a += my(s * N_PATHS + p);
      return a;
   endfunction

   // Path memory: data one cycle after the read strobe.
   always @(posedge clk) begin
      if (mem_rd_en === 1'b1) begin
         mem_rd_x <= mx(int'(mem_rd_addr));
         mem_rd_y <= my(int'(mem_rd_addr));
      end
   end

   // Accumulator stub: beta = {sum x, sum y, sum x ^ sum y}.
   logic             bv_q, force_bv, beta_en;
   int               samp_cnt, beta_cnt;
   logic [WIDTH-1:0] sx, sy;
   assign acc_beta_valid = bv_q | force_bv;
   always @(posedge clk) begin
      if (!rst_n) begin
         samp_cnt <= 0; beta_cnt <= -1; sx <= '0; sy <= '0; bv_q <= 1'b0;
         for (int i = 0; i < 3; i++) acc_beta[i] <= '0;
      end else begin
         if (acc_valid && acc_ready) begin
            if (samp_cnt == N_PATHS - 1) begin
               samp_cnt <= 0; sx <= '0; sy <= '0;
               acc_beta[0] <= sx + acc_x;
               acc_beta[1] <= sy + acc_y;
               acc_beta[2] <= (sx + acc_x) ^ (sy + acc_y);
               beta_cnt <= beta_en ? BETA_LAT : -1;
            end else begin
               samp_cnt <= samp_cnt + 1; sx <= sx + acc_x; sy <= sy + acc_y;
            end
         end else if (beta_cnt > 0) begin
            beta_cnt <= beta_cnt - 1;
         end else if (beta_cnt == 0) begin
            bv_q <= 1'b1; beta_cnt <= -1;
         end
         if (acc_beta_valid && acc_beta_ready) bv_q <= 1'b0;
      end
   end

   // Event log; tests take snapshots of sizes instead of clearing it.
   int               rd_q[$];
   int               wr_step_q[$];
   logic [WIDTH-1:0] wr_b0_q[$], wr_b1_q[$], wr_b2_q[$];
   int               done_cnt = 0;
   int               xfer_cnt = 0;
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (mem_rd_en === 1'b1) rd_q.push_back(int'(mem_rd_addr));
         if (coef_we === 1'b1) begin
            wr_step_q.push_back(int'(coef_step));
            wr_b0_q.push_back(coef_beta[0]);
            wr_b1_q.push_back(coef_beta[1]);
            wr_b2_q.push_back(coef_beta[2]);
         end
         if (done === 1'b1) done_cnt++;
         if (acc_valid === 1'b1 && acc_ready === 1'b1) xfer_cnt++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; acc_ready = 1'b1; beta_en = 1'b1; force_bv = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; acc_ready = 1'b1; beta_en = 1'b1; force_bv = 1'b0;
      tick(); tick();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || err_timeout !== 1'b0) begin
         failures++; $display("FAIL reset_status busy=%b done=%b err=%b expected 0 0 0", busy, done, err_timeout);
      end
      checks++;
      if (mem_rd_en !== 1'b0 || mem_rd_addr !== '0 || acc_valid !== 1'b0 || acc_beta_ready !== 1'b0) begin
         failures++; $display("FAIL reset_strobes rd_en=%b addr=%0d valid=%b bready=%b expected all 0",
                              mem_rd_en, mem_rd_addr, acc_valid, acc_beta_ready);
      end
      checks++;
      if (acc_x !== '0 || acc_y !== '0 || coef_we !== 1'b0 || coef_step !== '0) begin
         failures++; $display("FAIL reset_data acc_x=%h acc_y=%h we=%b step=%0d expected 0", acc_x, acc_y, coef_we, coef_step);
      end
      checks++;
      if (coef_beta[0] !== '0 || coef_beta[1] !== '0 || coef_beta[2] !== '0) begin
         failures++; $display("FAIL reset_beta got=%h %h %h expected 0", coef_beta[0], coef_beta[1], coef_beta[2]);
      end
      rst_n = 1'b1;
      tick(); tick();
      checks++;
      if (busy !== 1'b0 || mem_rd_en !== 1'b0) begin
         failures++; $display("FAIL idle_hold busy=%b rd_en=%b expected 0 0", busy, mem_rd_en);
      end
   endtask

   task automatic test_nominal();
      int rb, wb, db, c1, got;
      bit seen, last_we1;
      apply_reset();
      rb = rd_q.size(); wb = wr_step_q.size(); db = done_cnt;
      start = 1'b1; tick(); start = 1'b0;
      c1 = cyc;
      checks++;
      if (mem_rd_en !== 1'b1 || mem_rd_addr !== 16'd30 || busy !== 1'b1) begin
         failures++; $display("FAIL first_fetch rd_en=%b addr=%0d busy=%b expected 1 30 1", mem_rd_en, mem_rd_addr, busy);
      end
      tick();
      checks++;
      if (mem_rd_en !== 1'b0 || acc_valid !== 1'b0) begin
         failures++; $display("FAIL latch_cycle rd_en=%b valid=%b expected 0 0", mem_rd_en, acc_valid);
      end
      tick();
      checks++;
      if (acc_valid !== 1'b1 || acc_x !== mx(30) || acc_y !== my(30)) begin
         failures++; $display("FAIL first_send valid=%b x=%h y=%h expected 1 %h %h", acc_valid, acc_x, acc_y, mx(30), my(30));
      end
      seen = 1'b0; last_we1 = 1'b0;
      while (!seen && cyc - c1 < 400) begin
         tick();
         if (done === 1'b1) begin
            seen = 1'b1;
            checks++;
            if (!last_we1) begin
               failures++; $display("FAIL done_after_write previous_we_step1=%b expected 1", last_we1);
            end
         end
         last_we1 = (coef_we === 1'b1 && coef_step === STEP_W'(1));
      end
      checks++;
      if (!seen || cyc - c1 != NOM_CYC) begin
         failures++; $display("FAIL nominal_latency seen=%b cycles=%0d expected %0d", seen, cyc - c1, NOM_CYC);
      end
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || err_timeout !== 1'b0) begin
         failures++; $display("FAIL nominal_end done=%b busy=%b err=%b expected 0 0 0", done, busy, err_timeout);
      end
      checks++;
      if (rd_q.size() - rb != 3 * N_PATHS) begin
         failures++; $display("FAIL nominal_reads got=%0d expected %0d", rd_q.size() - rb, 3 * N_PATHS);
      end
      for (int i = 0; i < 3 * N_PATHS; i++) begin
         got = (rb + i < rd_q.size()) ? rd_q[rb + i] : -1;
         checks++;
         if (got != exp_addr(i)) begin
            failures++; $display("FAIL nominal_addr[%0d] got=%0d expected %0d", i, got, exp_addr(i));
         end
      end
      checks++;
      if (wr_step_q.size() - wb != 3 || done_cnt - db != 1) begin
         failures++; $display("FAIL nominal_counts writes=%0d dones=%0d expected 3 1", wr_step_q.size() - wb, done_cnt - db);
      end else begin
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (wr_step_q[wb + k] != N_STEPS - 1 - k || wr_b0_q[wb + k] !== exp_sx(N_STEPS - 1 - k) ||
                wr_b1_q[wb + k] !== exp_sy(N_STEPS - 1 - k) ||
                wr_b2_q[wb + k] !== (exp_sx(N_STEPS - 1 - k) ^ exp_sy(N_STEPS - 1 - k))) begin
               failures++; $display("FAIL nominal_write[%0d] step=%0d b0=%h b1=%h b2=%h expected step=%0d b0=%h b1=%h",
                                    k, wr_step_q[wb + k], wr_b0_q[wb + k], wr_b1_q[wb + k], wr_b2_q[wb + k],
                                    N_STEPS - 1 - k, exp_sx(N_STEPS - 1 - k), exp_sy(N_STEPS - 1 - k));
            end
         end
      end
   endtask

   task automatic test_stall();
      int xb, wb, c1;
      logic [WIDTH-1:0] x0, y0;
      apply_reset();
      xb = xfer_cnt; wb = wr_step_q.size();
      start = 1'b1; tick(); start = 1'b0;
      c1 = cyc;
      while (!(acc_valid === 1'b1 && xfer_cnt - xb == 3) && cyc - c1 < 100) tick();
      acc_ready = 1'b0;
      x0 = acc_x; y0 = acc_y;
      checks++;
      if (x0 !== mx(33) || y0 !== my(33)) begin
         failures++; $display("FAIL stall_sample x=%h y=%h expected %h %h", x0, y0, mx(33), my(33));
      end
      for (int k = 0; k < 5; k++) begin
         tick();
         checks++;
         if (acc_valid !== 1'b1 || acc_x !== x0 || acc_y !== y0 || xfer_cnt - xb != 3) begin
            failures++; $display("FAIL stall_hold[%0d] valid=%b x=%h y=%h xfers=%0d expected 1 %h %h 3",
                                 k, acc_valid, acc_x, acc_y, xfer_cnt - xb, x0, y0);
         end
      end
      acc_ready = 1'b1;
      tick();
      checks++;
      if (xfer_cnt - xb != 4 || acc_valid !== 1'b0 || mem_rd_addr !== 16'd34) begin
         failures++; $display("FAIL stall_release xfers=%0d valid=%b addr=%0d expected 4 0 34", xfer_cnt - xb, acc_valid, mem_rd_addr);
      end
      while (done !== 1'b1 && cyc - c1 < 400) tick();
      checks++;
      if (done !== 1'b1 || cyc - c1 != NOM_CYC + 5) begin
         failures++; $display("FAIL stall_latency done=%b cycles=%0d expected %0d", done, cyc - c1, NOM_CYC + 5);
      end
      checks++;
      if (xfer_cnt - xb != 3 * N_PATHS || wr_step_q.size() - wb != 3 || wr_b0_q[wb] !== exp_sx(3)) begin
         failures++; $display("FAIL stall_totals xfers=%0d writes=%0d expected %0d 3", xfer_cnt - xb, wr_step_q.size() - wb, 3 * N_PATHS);
      end
   endtask

   task automatic test_start_while_busy();
      int rb, wb, c1, bad;
      apply_reset();
      rb = rd_q.size(); wb = wr_step_q.size();
      start = 1'b1; tick(); start = 1'b0;
      c1 = cyc;
      while (!(mem_rd_en === 1'b1 && mem_rd_addr === 16'd22) && cyc - c1 < 200) tick();
      start = 1'b1; tick(); start = 1'b0;
      checks++;
      if (busy !== 1'b1 || mem_rd_en !== 1'b0) begin
         failures++; $display("FAIL busy_start_state busy=%b rd_en=%b expected 1 0", busy, mem_rd_en);
      end
      while (done !== 1'b1 && cyc - c1 < 400) tick();
      checks++;
      if (done !== 1'b1 || cyc - c1 != NOM_CYC) begin
         failures++; $display("FAIL busy_start_latency done=%b cycles=%0d expected %0d", done, cyc - c1, NOM_CYC);
      end
      bad = 0;
      for (int i = 0; i < 3 * N_PATHS; i++)
         if (rb + i >= rd_q.size() || rd_q[rb + i] != exp_addr(i)) bad++;
      checks++;
      if (bad != 0 || rd_q.size() - rb != 3 * N_PATHS || wr_step_q.size() - wb != 3) begin
         failures++; $display("FAIL busy_start_sequence bad_addrs=%0d reads=%0d writes=%0d expected 0 %0d 3",
                              bad, rd_q.size() - rb, wr_step_q.size() - wb, 3 * N_PATHS);
      end
   endtask

   task automatic test_timeout();
      int wb, db, c1, n;
      bit early;
      apply_reset();
      beta_en = 1'b0;
      wb = wr_step_q.size(); db = done_cnt;
      start = 1'b1; tick(); start = 1'b0;
      c1 = cyc;
      while (acc_beta_ready !== 1'b1 && cyc - c1 < 200) tick();
      n = 0; early = 1'b0;
      while (acc_beta_ready === 1'b1 && n < 100) begin
         if (err_timeout !== 1'b0) early = 1'b1;
         tick(); n++;
      end
      checks++;
      if (n != TIMEOUT || early) begin
         failures++; $display("FAIL timeout_cycles got=%0d early_err=%b expected %0d 0", n, early, TIMEOUT);
      end
      checks++;
      if (err_timeout !== 1'b1 || busy !== 1'b0) begin
         failures++; $display("FAIL timeout_flag err=%b busy=%b expected 1 0", err_timeout, busy);
      end
      tick(); tick();
      checks++;
      if (wr_step_q.size() - wb != 0 || done_cnt - db != 0 || err_timeout !== 1'b1) begin
         failures++; $display("FAIL timeout_quiet writes=%0d dones=%0d err=%b expected 0 0 1",
                              wr_step_q.size() - wb, done_cnt - db, err_timeout);
      end
      start = 1'b1; tick(); start = 1'b0;
      checks++;
      if (err_timeout !== 1'b0 || busy !== 1'b1 || mem_rd_addr !== 16'd30) begin
         failures++; $display("FAIL timeout_clear err=%b busy=%b addr=%0d expected 0 1 30", err_timeout, busy, mem_rd_addr);
      end
   endtask

   task automatic test_midrun_reset();
      int wb, c1;
      apply_reset();
      start = 1'b1; tick(); start = 1'b0;
      c1 = cyc;
      while (!(acc_valid === 1'b1 && mem_rd_addr === '0 && acc_x === mx(22)) && cyc - c1 < 200) tick();
      rst_n = 1'b0;
      tick(); tick();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || mem_rd_en !== 1'b0 || acc_valid !== 1'b0 || acc_x !== '0 ||
          acc_beta_ready !== 1'b0 || coef_we !== 1'b0 || coef_beta[0] !== '0) begin
         failures++; $display("FAIL midrun_reset busy=%b valid=%b x=%h we=%b b0=%h expected all 0",
                              busy, acc_valid, acc_x, coef_we, coef_beta[0]);
      end
      rst_n = 1'b1;
      tick();
      wb = wr_step_q.size();
      start = 1'b1; tick(); start = 1'b0;
      c1 = cyc;
      checks++;
      if (mem_rd_en !== 1'b1 || mem_rd_addr !== 16'd30) begin
         failures++; $display("FAIL restart_addr rd_en=%b addr=%0d expected 1 30", mem_rd_en, mem_rd_addr);
      end
      while (done !== 1'b1 && cyc - c1 < 400) tick();
      checks++;
      if (done !== 1'b1 || cyc - c1 != NOM_CYC || wr_step_q.size() - wb != 3 || wr_b0_q[wb] !== exp_sx(3)) begin
         failures++; $display("FAIL restart_run done=%b cycles=%0d writes=%0d expected 1 %0d 3",
                              done, cyc - c1, wr_step_q.size() - wb, NOM_CYC);
      end
   endtask

   task automatic test_abort();
      int wb, db, c1;
      apply_reset();
      beta_en = 1'b0;
      abort = 1'b1; start = 1'b1; tick(); abort = 1'b0; start = 1'b0;
      checks++;
      if (busy !== 1'b0 || mem_rd_en !== 1'b0) begin
         failures++; $display("FAIL abort_beats_start busy=%b rd_en=%b expected 0 0", busy, mem_rd_en);
      end
      wb = wr_step_q.size(); db = done_cnt;
      start = 1'b1; tick(); start = 1'b0;
      c1 = cyc;
      while (acc_beta_ready !== 1'b1 && cyc - c1 < 200) tick();
      tick();
      abort = 1'b1; force_bv = 1'b1;
      tick();
      abort = 1'b0; force_bv = 1'b0;
      checks++;
      if (busy !== 1'b0 || acc_beta_ready !== 1'b0 || coef_we !== 1'b0) begin
         failures++; $display("FAIL abort_collect busy=%b bready=%b we=%b expected 0 0 0", busy, acc_beta_ready, coef_we);
      end
      repeat (5) tick();
      checks++;
      if (wr_step_q.size() - wb != 0 || done_cnt - db != 0 || busy !== 1'b0) begin
         failures++; $display("FAIL abort_quiet writes=%0d dones=%0d busy=%b expected 0 0 0",
                              wr_step_q.size() - wb, done_cnt - db, busy);
      end
      apply_reset();
      start = 1'b1; tick(); start = 1'b0;
      tick(); tick();
      abort = 1'b1; tick(); abort = 1'b0;
      checks++;
      if (acc_valid !== 1'b0 || busy !== 1'b0 || mem_rd_en !== 1'b0) begin
         failures++; $display("FAIL abort_send valid=%b busy=%b rd_en=%b expected 0 0 0", acc_valid, busy, mem_rd_en);
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; acc_ready = 1'b1; beta_en = 1'b1; force_bv = 1'b0;
      test_reset();
      test_nominal();
      test_stall();
      test_start_while_busy();
      test_timeout();
      test_midrun_reset();
      test_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
